demux1to2_buf: RTL and testbench

- Reverse-direction counterpart of the 32-bit 2:1 datapath mux: takes one producer stream and steers each word to one of two consumers, selected per word.
- Each destination has its own small FIFO, so a stalled consumer does not block words bound for the other one until its own FIFO fills.
- Sits between a single result/bus source in the multi-cycle CPU and two sinks, for example the register-file writeback path and the memory-write path.
- All handshakes are valid/ready.

---
 rtl/demux1to2_buf.sv | 126 ++++++++++++
 tb/tb_demux1to2_buf.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_buf.sv
// demux1to2_buf: steers one valid/ready producer stream to two consumers.
// Each destination has its own DEPTH-entry FIFO, so a stalled consumer only
// blocks words bound for itself, and only once its own FIFO is full.
// FIFO index 0 drives the a_* port and index 1 drives the b_* port.
// Optional build macro DEMUX1TO2_STATS_EN adds stat_a/stat_b, which are
// wrapping 32-bit counts of words accepted into each FIFO.
module demux1to2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [CW-1:0]    a_count,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CW-1:0]    b_count
`ifdef DEMUX1TO2_STATS_EN
  ,
  output logic [31:0]      stat_a,
  output logic [31:0]      stat_b
`endif
);

  localparam int PW = $clog2(DEPTH);

  // Per-FIFO views, index 0 = A, index 1 = B.
  logic [1:0][WIDTH-1:0] head_data;
  logic [1:0]            head_valid;
  logic [1:0]            fifo_full;
  logic [1:0][CW-1:0]    fifo_count;
  logic [1:0]            out_ready;
`ifdef DEMUX1TO2_STATS_EN
  logic [1:0][31:0]      stat_cnt;
`endif

  assign out_ready = {b_ready, a_ready};

  // Acceptance depends only on the selected FIFO's registered count, so a
  // consumer popping in the same cycle cannot open up a full FIFO.
  assign in_ready = ~fifo_full[in_sel];

  assign a_data  = head_data[0];
  assign a_valid = head_valid[0];
  assign a_count = fifo_count[0];
  assign b_data  = head_data[1];
  assign b_valid = head_valid[1];
  assign b_count = fifo_count[1];
`ifdef DEMUX1TO2_STATS_EN
  assign stat_a = stat_cnt[0];
  assign stat_b = stat_cnt[1];
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;
    logic             not_empty;

    assign not_empty = (count_q != '0);
    assign push      = in_valid && !fifo_full[gi] && (in_sel == 1'(gi));
    assign pop       = not_empty && out_ready[gi];

    assign fifo_full[gi]  = (count_q == CW'(DEPTH));
    assign fifo_count[gi] = count_q;
    assign head_valid[gi] = not_empty;
    // Head word is forced to zero when empty so stale storage never leaks out.
    assign head_data[gi]  = not_empty ? mem_q[rd_ptr_q] : '0;

    // Next-state pointers and occupancy from this cycle's push/pop pair.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage write; contents need no reset because the head is gated by count.
    always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef DEMUX1TO2_STATS_EN
    logic [31:0] stat_q;

    // Accepted-push counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
      if (!rst_n)    stat_q <= '0;
      else if (push) stat_q <= stat_q + 32'd1;
    end

    assign stat_cnt[gi] = stat_q;
`endif
  end

endmodule

// File: tb/tb_demux1to2_buf.sv
// Directed, table-driven bench for demux1to2_buf (WIDTH=32, DEPTH=2).
// Each table row gives the inputs driven for one cycle together with the
// outputs expected before that cycle's rising edge.
module tb_demux1to2_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [CW-1:0]    a_count;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CW-1:0]    b_count;
`ifdef DEMUX1TO2_STATS_EN
  logic [31:0]      stat_a;
  logic [31:0]      stat_b;
`endif

  int checks   = 0;
  int failures = 0;
  string ctx;

  demux1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_count  (a_count),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_count  (b_count)
`ifdef DEMUX1TO2_STATS_EN
    ,
    .stat_a   (stat_a),
    .stat_b   (stat_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        ar;
    logic        br;
    logic        ir;
    logic        av;
    logic [31:0] ad;
    int          ac;
    logic        bv;
    logic [31:0] bd;
    int          bc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic [31:0] d, input logic ar, input logic br,
                              input logic ir, input logic av, input logic [31:0] ad,
                              input int ac, input logic bv, input logic [31:0] bd,
                              input int bc);
    vec_t t;
    t.rst = r; t.v = v; t.sel = s; t.d = d; t.ar = ar; t.br = br;
    t.ir = ir; t.av = av; t.ad = ad; t.ac = ac; t.bv = bv; t.bd = bd; t.bc = bc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s %s: got 0x%0h required 0x%0h", ctx, nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [31:0] d, input logic ar, input logic br);
    rst_n = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
  endtask

  task automatic chk_all(input logic ir, input logic av, input logic [31:0] ad,
                         input int ac, input logic bv, input logic [31:0] bd, input int bc);
    chk("in_ready", 32'(in_ready), 32'(ir));
    chk("a_valid",  32'(a_valid),  32'(av));
    chk("a_data",   a_data,        ad);
    chk("a_count",  32'(a_count),  ac);
    chk("b_valid",  32'(b_valid),  32'(bv));
    chk("b_data",   b_data,        bd);
    chk("b_count",  32'(b_count),  bc);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //        rst v  s  data    ar br | ir av a_data  ac bv b_data  bc
    // Reset held (two more edges after the preamble edge), then idle.
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0, 32'h0,   0));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0, 32'h0,   0));
    vecs.push_back(mk(1, 0, 1, 32'h0,   1, 1,  1, 0, 32'h0,   0, 0, 32'h0,   0));
    // Steering and order.
    vecs.push_back(mk(1, 1, 0, 32'h11,  0, 0,  1, 0, 32'h0,   0, 0, 32'h0,   0));
    vecs.push_back(mk(1, 1, 1, 32'h22,  0, 0,  1, 1, 32'h11,  1, 0, 32'h0,   0));
    vecs.push_back(mk(1, 1, 0, 32'h33,  0, 0,  1, 1, 32'h11,  1, 1, 32'h22,  1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0,  0, 1, 32'h11,  2, 1, 32'h22,  1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 0,  0, 1, 32'h11,  2, 1, 32'h22,  1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 0,  1, 1, 32'h33,  1, 1, 32'h22,  1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 0,  1, 0, 32'h0,   0, 1, 32'h22,  1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 1,  1, 0, 32'h0,   0, 1, 32'h22,  1));
    // Full and back-pressure.
    vecs.push_back(mk(1, 1, 0, 32'hA0,  0, 0,  1, 0, 32'h0,   0, 0, 32'h0,   0));
    vecs.push_back(mk(1, 1, 0, 32'hA1,  0, 0,  1, 1, 32'hA0,  1, 0, 32'h0,   0));
    vecs.push_back(mk(1, 1, 0, 32'hA2,  0, 0,  0, 1, 32'hA0,  2, 0, 32'h0,   0));
    vecs.push_back(mk(1, 1, 0, 32'hA2,  0, 0,  0, 1, 32'hA0,  2, 0, 32'h0,   0));
    vecs.push_back(mk(1, 1, 1, 32'hA2,  0, 0,  1, 1, 32'hA0,  2, 0, 32'h0,   0));
    // Full with simultaneous pop: no push, then push next cycle.
    vecs.push_back(mk(1, 1, 0, 32'hB0,  1, 0,  0, 1, 32'hA0,  2, 1, 32'hA2,  1));
    vecs.push_back(mk(1, 1, 0, 32'hB0,  0, 0,  1, 1, 32'hA1,  1, 1, 32'hA2,  1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0,  0, 1, 32'hA1,  2, 1, 32'hA2,  1));
    vecs.push_back(mk(1, 0, 1, 32'h0,   0, 1,  1, 1, 32'hA1,  2, 1, 32'hA2,  1));

    @(negedge clk);  // preamble: first reset edge has passed
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ar, vecs[i].br);
      #1;
      ctx = $sformatf("row%0d", i);
      chk_all(vecs[i].ir, vecs[i].av, vecs[i].ad, vecs[i].ac, vecs[i].bv, vecs[i].bd, vecs[i].bc);
      $display("row %0d: rst_n=%0b v=%0b sel=%0b d=%0h ar=%0b br=%0b -> ir=%0b a=%0b/%0h/%0d b=%0b/%0h/%0d",
               i, rst_n, in_valid, in_sel, in_data, a_ready, b_ready,
               in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count);
      @(negedge clk);
    end

    // Stream 10 words through B with b_ready held: count stays 0/1 across wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
      #1;
      ctx = $sformatf("stream%0d", i);
      chk_all(1'b1, 1'b1, 32'hA1, 2, (i != 0), (i == 0) ? 32'h0 : 32'h100 + 32'(i - 1),
              (i == 0) ? 0 : 1);
      $display("stream %0d: push 0x%0h b_valid=%0b b_data=0x%0h b_count=%0d",
               i, in_data, b_valid, b_data, b_count);
      @(negedge clk);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    #1;
    ctx = "stream_tail";
    chk_all(1'b1, 1'b1, 32'hA1, 2, 1'b1, 32'h109, 1);
    @(negedge clk);

    // Load B with one word while A still holds A1,B0.
    drive(1'b1, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
    #1;
    ctx = "load_b";
    chk_all(1'b1, 1'b1, 32'hA1, 2, 1'b0, 32'h0, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    ctx = "pre_reset";
    chk_all(1'b0, 1'b1, 32'hA1, 2, 1'b1, 32'h55, 1);
`ifdef DEMUX1TO2_STATS_EN
    chk("stat_a", stat_a, 32'd5);
    chk("stat_b", stat_b, 32'd13);
`endif
    @(negedge clk);

    // Mid-operation reset with the producer still pushing: reset wins.
    drive(1'b0, 1'b1, 1'b0, 32'h77, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    ctx = "post_reset";
    chk_all(1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h0, 0);
`ifdef DEMUX1TO2_STATS_EN
    chk("stat_a", stat_a, 32'd0);
    chk("stat_b", stat_b, 32'd0);
`endif
    $display("reset: a_valid=%0b b_valid=%0b a_count=%0d b_count=%0d", a_valid, b_valid, a_count, b_count);
    @(negedge clk);
    #1;
    ctx = "post_reset_idle";
    chk_all(1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
